izhikevich_array: RTL and testbench

//  Time-multiplexed bank of NUM_NEURONS Izhikevich neurons sharing one update datapath.

---
 rtl/izh_pkg.sv | 52 +++++
 rtl/izh_update.sv | 84 ++++++++
 rtl/izhikevich_array.sv | 165 ++++++++++++++++
 tb/tb_izhikevich_array.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared fixed-point word, constants and saturating arithmetic for the Izhikevich neuron bank.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: fx_t word, SAT_MAX/SAT_MIN, K004/K5/K140 model constants, sat_add/sat_sub/fmul, FSM state enum.
package izh_pkg;

  // The arithmetic word is fixed here; the top checks its N/Q parameters against these.
  localparam int IZH_N = 18;
  localparam int IZH_Q = 8;

  typedef logic signed [IZH_N-1:0] fx_t;

  localparam fx_t SAT_MAX = fx_t'({1'b0, {(IZH_N-1){1'b1}}});
  localparam fx_t SAT_MIN = fx_t'({1'b1, {(IZH_N-1){1'b0}}});

  // 0.04 rounded to nearest in Q format (10 at Q=8), 5.0 and 140.0.
  localparam fx_t K004 = fx_t'((4 * (1 << IZH_Q) + 50) / 100);
  localparam fx_t K5   = fx_t'(5 << IZH_Q);
  localparam fx_t K140 = fx_t'(140 << IZH_Q);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_UPDATE, ST_FIN} state_e;

  function automatic fx_t sat_wide(input logic signed [2*IZH_N-1:0] x);
    if (x > (2*IZH_N)'(SAT_MAX)) return SAT_MAX;
    if (x < (2*IZH_N)'(SAT_MIN)) return SAT_MIN;
    return x[IZH_N-1:0];
  endfunction

  function automatic fx_t sat_add(input fx_t x, input fx_t y);
    logic signed [IZH_N:0] s;
    s = (IZH_N+1)'(x) + (IZH_N+1)'(y);
    // One guard bit: overflow iff the top two bits disagree.
    if (s[IZH_N] != s[IZH_N-1]) return s[IZH_N] ? SAT_MIN : SAT_MAX;
    return s[IZH_N-1:0];
  endfunction

  function automatic fx_t sat_sub(input fx_t x, input fx_t y);
    logic signed [IZH_N:0] s;
    s = (IZH_N+1)'(x) - (IZH_N+1)'(y);
    if (s[IZH_N] != s[IZH_N-1]) return s[IZH_N] ? SAT_MIN : SAT_MAX;
    return s[IZH_N-1:0];
  endfunction

  // Full-width product, arithmetic shift back to Q format (floor), then clamp.
  function automatic fx_t fmul(input fx_t x, input fx_t y);
    logic signed [2*IZH_N-1:0] p;
    p = (2*IZH_N)'(x) * (2*IZH_N)'(y);
    p = p >>> IZH_Q;
    return sat_wide(p);
  endfunction

endpackage

// File: rtl/izh_update.sv
// Combinational Izhikevich update for one neuron: integrate v/w, spike test, refractory countdown.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: v_i/w_i/i_i/ref_i fetched state, a_i..dw_step_i shared parameters,
//        v_next_o/w_next_o/ref_next_o/spike_o write-back values.
module izh_update
  import izh_pkg::*;
#(
  parameter int REF_STEPS = 0,
  parameter int RW        = 1
) (
  input  logic [IZH_N-1:0] v_i,
  input  logic [IZH_N-1:0] w_i,
  input  logic [IZH_N-1:0] i_i,
  input  logic [RW-1:0]    ref_i,
  input  logic [IZH_N-1:0] a_i,
  input  logic [IZH_N-1:0] b_i,
  input  logic [IZH_N-1:0] c_i,
  input  logic [IZH_N-1:0] d_i,
  input  logic [IZH_N-1:0] v_th_i,
  input  logic [IZH_N-1:0] dv_step_i,
  input  logic [IZH_N-1:0] dw_step_i,
  output logic [IZH_N-1:0] v_next_o,
  output logic [IZH_N-1:0] w_next_o,
  output logic [RW-1:0]    ref_next_o,
  output logic             spike_o
);

  fx_t v, w, cur, a, b, c, d, vth, dvs, dws;
  assign v   = v_i;
  assign w   = w_i;
  assign cur = i_i;
  assign a   = a_i;
  assign b   = b_i;
  assign c   = c_i;
  assign d   = d_i;
  assign vth = v_th_i;
  assign dvs = dv_step_i;
  assign dws = dw_step_i;

  fx_t kvv, k5v, s1, s2, s3, s4, dv, bv, u, au, dw;
  fx_t v_nx, w_nx;
  logic [RW-1:0] ref_nx;
  logic spk;

  always_comb begin
    // 0.04*v*v evaluated left to right, (K004*v)*v, which keeps the
    // intermediate small for typical membrane voltages.
    kvv = fmul(fmul(K004, v), v);
    k5v = fmul(K5, v);
    s1  = sat_add(kvv, k5v);
    s2  = sat_add(s1, K140);
    s3  = sat_sub(s2, w);
    s4  = sat_add(s3, cur);
    dv  = fmul(s4, dvs);

    bv  = fmul(b, v);
    u   = sat_sub(bv, w);
    au  = fmul(a, u);
    dw  = fmul(au, dws);

    v_nx   = sat_add(v, dv);
    w_nx   = sat_add(w, dw);
    ref_nx = '0;
    spk    = 1'b0;

    if (ref_i != '0) begin
      // Refractory: clamp v at reset value but let recovery keep evolving.
      v_nx   = c;
      ref_nx = ref_i - RW'(1);
    end else if (v > vth) begin
      v_nx   = c;
      w_nx   = sat_add(w, d);
      spk    = 1'b1;
      ref_nx = RW'(REF_STEPS);
    end
  end

  assign v_next_o   = v_nx;
  assign w_next_o   = w_nx;
  assign ref_next_o = ref_nx;
  assign spike_o    = spk;

endmodule

// File: rtl/izhikevich_array.sv
// Time-multiplexed bank of Izhikevich neurons; one start pulse sweeps FETCH/UPDATE over every neuron.
// Latency: start at T -> busy T+1..T+2*NUM_NEURONS -> done pulse at T+2*NUM_NEURONS+1.
// Backpressure: start and cfg_we are dropped unless the FSM is idle; no stall inside a sweep.
// Ports: clk/rst (sync, active-high), start, i_vec currents, a/b/c/d/v_th/dv_step/dw_step parameters,
//        cfg_we/cfg_idx/cfg_v/cfg_w init port, rd_v/rd_w readback of cfg_idx, busy, done, spike_vec.
module izhikevich_array
  import izh_pkg::*;
#(
  parameter int N           = IZH_N,
  parameter int Q           = IZH_Q,
  parameter int NUM_NEURONS = 4,
  parameter int REF_STEPS   = 0,
  localparam int IW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_NEURONS*N-1:0] i_vec,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  input  logic [N-1:0]             c,
  input  logic [N-1:0]             d,
  input  logic [N-1:0]             v_th,
  input  logic [N-1:0]             dv_step,
  input  logic [N-1:0]             dw_step,
  input  logic                     cfg_we,
  input  logic [IW-1:0]            cfg_idx,
  input  logic [N-1:0]             cfg_v,
  input  logic [N-1:0]             cfg_w,
  output logic [N-1:0]             rd_v,
  output logic [N-1:0]             rd_w,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_NEURONS-1:0]   spike_vec
);

  localparam int RW = (REF_STEPS > 0) ? $clog2(REF_STEPS + 1) : 1;

  // The datapath functions are built for the package word format.
  if (N != IZH_N || Q != IZH_Q) begin : g_fmt_check
    $error("izhikevich_array: N/Q must match izh_pkg IZH_N/IZH_Q");
  end

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic sweep_go, cfg_go, idx_ok;

  logic [N-1:0]  v_q   [NUM_NEURONS];
  logic [N-1:0]  w_q   [NUM_NEURONS];
  logic [RW-1:0] ref_q [NUM_NEURONS];

  // Pipeline stage between FETCH and UPDATE.
  logic [N-1:0]  pv_q, pw_q, pi_q;
  logic [RW-1:0] pref_q;

  logic [NUM_NEURONS-1:0] spike_q;

  logic [N-1:0]  v_nx, w_nx;
  logic [RW-1:0] ref_nx;
  logic          spk;

  // Guards non-power-of-two banks against out-of-range indices.
  assign idx_ok = ({1'b0, cfg_idx} < (IW+1)'(NUM_NEURONS));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy     = 1'b0;
    done     = 1'b0;
    sweep_go = 1'b0;
    cfg_go   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_go = cfg_we && idx_ok;
        if (start) begin
          sweep_go = 1'b1;
          idx_d    = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy    = 1'b1;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        busy = 1'b1;
        if (idx_q == IW'(NUM_NEURONS - 1)) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  izh_update #(
    .REF_STEPS (REF_STEPS),
    .RW        (RW)
  ) u_update (
    .v_i        (pv_q),
    .w_i        (pw_q),
    .i_i        (pi_q),
    .ref_i      (pref_q),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .d_i        (d),
    .v_th_i     (v_th),
    .dv_step_i  (dv_step),
    .dw_step_i  (dw_step),
    .v_next_o   (v_nx),
    .w_next_o   (w_nx),
    .ref_next_o (ref_nx),
    .spike_o    (spk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pv_q    <= '0;
      pw_q    <= '0;
      pi_q    <= '0;
      pref_q  <= '0;
      spike_q <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_q[k]   <= '0;
        w_q[k]   <= '0;
        ref_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (sweep_go) spike_q <= '0;
      if (cfg_go) begin
        v_q[cfg_idx]   <= cfg_v;
        w_q[cfg_idx]   <= cfg_w;
        ref_q[cfg_idx] <= '0;
      end
      if (state_q == ST_FETCH) begin
        pv_q   <= v_q[idx_q];
        pw_q   <= w_q[idx_q];
        pi_q   <= i_vec[idx_q*N +: N];
        pref_q <= ref_q[idx_q];
      end
      if (state_q == ST_UPDATE) begin
        v_q[idx_q]   <= v_nx;
        w_q[idx_q]   <= w_nx;
        ref_q[idx_q] <= ref_nx;
        if (spk) spike_q[idx_q] <= 1'b1;
      end
    end
  end

  assign rd_v      = idx_ok ? v_q[cfg_idx] : '0;
  assign rd_w      = idx_ok ? w_q[cfg_idx] : '0;
  assign spike_vec = spike_q;

endmodule

// File: tb/tb_izhikevich_array.sv
// Directed bench for izhikevich_array: sweep timing, spike/reset, refractory, saturation,
// quiescent recovery with blocked config, nonzero recovery update, and reset mid-sweep.
module tb_izhikevich_array;

  logic        clk;
  logic        rst;
  logic        start;
  logic [71:0] i_vec;
  logic [17:0] a, b, c, d, v_th, dv_step, dw_step;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [17:0] cfg_v, cfg_w;
  logic [17:0] rd_v, rd_w;
  logic        busy, done;
  logic [3:0]  spike_vec;

  int n_vec = 0;
  int n_err = 0;

  izhikevich_array #(
    .N           (18),
    .Q           (8),
    .NUM_NEURONS (4),
    .REF_STEPS   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .i_vec     (i_vec),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .v_th      (v_th),
    .dv_step   (dv_step),
    .dw_step   (dw_step),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_v     (cfg_v),
    .cfg_w     (cfg_w),
    .rd_v      (rd_v),
    .rd_w      (rd_w),
    .busy      (busy),
    .done      (done),
    .spike_vec (spike_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input int v, input int w);
    cfg_we  = 1'b1;
    cfg_idx = idx[1:0];
    cfg_v   = v[17:0];
    cfg_w   = w[17:0];
    tick;
    cfg_we  = 1'b0;
  endtask

  task automatic check_nrn(input string tag, input int idx, input int ev, input int ew);
    cfg_idx = idx[1:0];
    #1;
    check_val({tag, "_v"}, $signed(rd_v), ev);
    check_val({tag, "_w"}, $signed(rd_w), ew);
  endtask

  // One full sweep; optionally hammers cfg_we on neuron 2 while busy.
  task automatic run_sweep(input string tag, input bit busy_cfg);
    bit seen;
    seen  = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    if (busy_cfg) begin
      cfg_we  = 1'b1;
      cfg_idx = 2'd2;
      cfg_v   = 18'd12345;
      cfg_w   = 18'd777;
    end
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1'b1;
      else tick;
    end
    cfg_we = 1'b0;
    check_val({tag, "_done"}, seen, 1);
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit any_done;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_v = '0; cfg_w = '0;
    i_vec = '0; a = '0; b = '0; c = '0; d = '0; v_th = '0; dv_step = '0; dw_step = '0;
    tick; tick; tick;
    rst = 1'b0;

    // Reset state
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_spike", spike_vec, 0);
    check_nrn("rst_n0", 0, 0, 0);

    c = -18'sd16640; d = 18'd2048; v_th = 18'd7680;

    // Sweep timing: start at cycle 0, stray start at cycle 3 must be ignored
    start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick;
      start = (cyc == 3);
      check_val($sformatf("tim_busy_c%0d", cyc), busy, (cyc <= 8) ? 1 : 0);
      check_val($sformatf("tim_done_c%0d", cyc), done, (cyc == 9) ? 1 : 0);
    end
    start = 1'b0;

    // Spike: neuron0 v=35.0 over threshold 30.0 -> v=c, w=0+d
    cfg(0, 8960, 0);
    cfg(1, 0, 35840);
    cfg(2, 0, 35840);
    cfg(3, 0, 35840);
    run_sweep("spk", 1'b0);
    check_val("spk_vec", spike_vec, 4'b0001);
    check_nrn("spk_n0", 0, -16640, 2048);
    check_nrn("spk_n1", 1, 0, 35840);

    // Refractory: two held sweeps, then normal integration with i=200.0
    dv_step = 18'd256;
    i_vec   = {18'd0, 18'd0, 18'd0, 18'd51200};
    run_sweep("ref2", 1'b0);
    check_val("ref2_vec", spike_vec, 0);
    check_nrn("ref2_n0", 0, -16640, 2048);
    run_sweep("ref3", 1'b0);
    check_val("ref3_vec", spike_vec, 0);
    check_nrn("ref3_n0", 0, -16640, 2048);
    run_sweep("ref4", 1'b0);
    check_val("ref4_vec", spike_vec, 0);
    // -650*-16640>>8=42250; -83200; +35840; -2048; +51200 -> dv=44042
    check_nrn("ref4_n0", 0, 27402, 2048);
    check_nrn("ref4_n1", 1, 0, 35840);

    // Saturation: every term clamps at +max, v must not wrap
    v_th  = 18'd131071;
    cfg(0, 131000, 0);
    i_vec = {18'd0, 18'd0, 18'd0, 18'd25600};
    run_sweep("sat", 1'b0);
    check_val("sat_vec", spike_vec, 0);
    check_nrn("sat_n0", 0, 131071, 0);

    // Quiescent recovery (a=0) with config writes attempted during the sweep
    i_vec = '0; b = 18'd256; dw_step = 18'd256;
    cfg(2, 0, 1000);
    run_sweep("qui", 1'b1);
    check_nrn("qui_n2", 2, 34840, 1000);
    check_nrn("qui_n1", 1, 0, 35840);

    // Nonzero recovery: a=1.0, b=0.25, dw_step=0.5, v frozen
    a = 18'd256; b = 18'd64; dw_step = 18'd128; dv_step = 18'd0;
    cfg(3, 1024, 100);
    run_sweep("dw", 1'b0);
    check_val("dw_vec", spike_vec, 0);
    check_nrn("dw_n3", 3, 1024, 178);
    check_nrn("dw_n1", 1, 0, 17920);

    // Reset mid-sweep: neuron0 (v=131071) spikes in cycle 2, rst in cycle 4
    v_th  = 18'd7680;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    check_val("mid_busy_pre", busy, 1);
    check_val("mid_spike_pre", spike_vec, 4'b0001);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_val("mid_busy", busy, 0);
    check_val("mid_spike", spike_vec, 0);
    for (int k = 0; k < 4; k++) check_nrn($sformatf("mid_n%0d", k), k, 0, 0);
    any_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) any_done = 1'b1;
      tick;
    end
    check_val("mid_no_done", any_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
